// File: rtl/board_referee_pkg.sv
// Shared definitions for the tic-tac-toe referee: cell and game codes, FSM states, winning lines.
// Difficulty codes live here so the CPU move generator agrees with the referee on encodings.
package board_referee_pkg;

    localparam logic [1:0]  CELL_X      = 2'd0;
    localparam logic [1:0]  CELL_O      = 2'd1;
    localparam logic [1:0]  CELL_EMPTY  = 2'd2;
    localparam logic [17:0] BOARD_EMPTY = 18'h2AAAA;
    localparam logic [3:0]  LAST_CELL   = 4'd8;
    localparam logic [3:0]  FULL_COUNT  = 4'd9;

    typedef enum logic [1:0] {
        GS_PLAYING = 2'd0,
        GS_X_WIN   = 2'd1,
        GS_O_WIN   = 2'd2,
        GS_DRAW    = 2'd3
    } game_state_t;

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_CHECK = 2'd1,
        ST_EVAL  = 2'd2,
        ST_OVER  = 2'd3
    } ref_state_t;

    typedef enum logic [1:0] {
        DIFF_EASY   = 2'd0,
        DIFF_NORMAL = 2'd1,
        DIFF_HARD   = 2'd2
    } difficulty_t;

    // Rows, columns, then the two diagonals.
    localparam logic [3:0] WIN_LINES [8][3] = '{
        '{4'd0, 4'd1, 4'd2}, '{4'd3, 4'd4, 4'd5}, '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6}, '{4'd1, 4'd4, 4'd7}, '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8}, '{4'd2, 4'd4, 4'd6}
    };

    // Out-of-range indices read as the never-driven code so they can never look empty.
    function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] idx);
        logic [1:0] c;
        c = 2'd3;
        for (int i = 0; i < 9; i++) begin
            if (4'(i) == idx) c = b[2*i +: 2];
        end
        return c;
    endfunction

endpackage

// File: rtl/board_referee_if.sv
// Move request handshake between a player source (human or CPU generator) and the referee.
interface board_referee_if;
    logic       move_valid;
    logic       move_player;
    logic [3:0] move_coord;
    logic       move_ready;
    logic       move_ack;
    logic       move_err;

    modport master (output move_valid, move_player, move_coord,
                    input  move_ready, move_ack, move_err);
    modport slave  (input  move_valid, move_player, move_coord,
                    output move_ready, move_ack, move_err);
endinterface

// File: rtl/board_referee_line_checker.sv
// Combinational scan of the 8 winning lines for three equal non-empty cells.
module line_checker
    import board_referee_pkg::*;
(
    input  logic [17:0] board,
    output logic        x_win,
    output logic        o_win
);

    logic [1:0] a, b, c;

    always_comb begin
        x_win = 1'b0;
        o_win = 1'b0;
        a = CELL_EMPTY;
        b = CELL_EMPTY;
        c = CELL_EMPTY;
        for (int l = 0; l < 8; l++) begin
            a = cell_at(board, WIN_LINES[l][0]);
            b = cell_at(board, WIN_LINES[l][1]);
            c = cell_at(board, WIN_LINES[l][2]);
            if (a == b && b == c) begin
                if (a == CELL_X) x_win = 1'b1;
                if (a == CELL_O) o_win = 1'b1;
            end
        end
    end

endmodule

// File: rtl/board_referee.sv
// Tic-tac-toe referee: accepts a move in WAIT, validates it in CHECK, scores the board in EVAL.
// A legal move is acknowledged three cycles after its handshake, an illegal one rejected after two.
module board_referee
    import board_referee_pkg::*;
#(
    parameter bit FIRST_PLAYER = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        new_game,
    board_referee_if.slave mv,
    output logic [17:0] board,
    output logic        turn,
    output logic        cpu_req,
    output logic [1:0]  game_state,
    output logic [3:0]  move_count
);

    ref_state_t  state, state_d;
    game_state_t gs_q, gs_d;
    logic [17:0] board_d;
    logic        turn_d, cpu_req_d;
    logic [3:0]  count_d;
    logic        ready_q, ready_d, ack_q, ack_d, err_q, err_d;
    logic        lat_player, lat_player_d;
    logic [3:0]  lat_coord, lat_coord_d;
    logic        legal, x_win, o_win;

    line_checker u_line_checker (
        .board (board),
        .x_win (x_win),
        .o_win (o_win)
    );

    assign legal = (lat_coord <= LAST_CELL) &&
                   (cell_at(board, lat_coord) == CELL_EMPTY) &&
                   (lat_player == turn);

    assign mv.move_ready = ready_q;
    assign mv.move_ack   = ack_q;
    assign mv.move_err   = err_q;
    assign game_state    = gs_q;

    always_ff @(posedge clock) begin
        if (reset) state <= ST_WAIT;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            ST_WAIT:  if (mv.move_valid) state_d = ST_CHECK;
            ST_CHECK: state_d = legal ? ST_EVAL : ST_WAIT;
            ST_EVAL:  state_d = (x_win || o_win || move_count == FULL_COUNT) ? ST_OVER : ST_WAIT;
            default:  state_d = ST_OVER;
        endcase
        if (new_game) state_d = ST_WAIT;
    end

    always_comb begin
        board_d      = board;
        turn_d       = turn;
        gs_d         = gs_q;
        count_d      = move_count;
        ready_d      = ready_q;
        ack_d        = 1'b0;
        err_d        = 1'b0;
        lat_player_d = lat_player;
        lat_coord_d  = lat_coord;
        case (state)
            ST_WAIT: begin
                if (mv.move_valid) begin
                    lat_player_d = mv.move_player;
                    lat_coord_d  = mv.move_coord;
                    ready_d      = 1'b0;
                end
            end
            ST_CHECK: begin
                if (legal) begin
                    for (int i = 0; i < 9; i++) begin
                        if (4'(i) == lat_coord) board_d[2*i +: 2] = {1'b0, lat_player};
                    end
                    count_d = move_count + 4'd1;
                end else begin
                    err_d   = 1'b1;
                    ready_d = 1'b1;
                end
            end
            ST_EVAL: begin
                ack_d  = 1'b1;
                turn_d = ~turn;
                // A line completed on the ninth move still counts as a win.
                if (x_win)                          gs_d = GS_X_WIN;
                else if (o_win)                     gs_d = GS_O_WIN;
                else if (move_count == FULL_COUNT)  gs_d = GS_DRAW;
                else                                gs_d = GS_PLAYING;
                ready_d = (gs_d == GS_PLAYING);
            end
            default: ready_d = 1'b0;
        endcase
        if (new_game) begin
            board_d = BOARD_EMPTY;
            turn_d  = FIRST_PLAYER;
            gs_d    = GS_PLAYING;
            count_d = 4'd0;
            ready_d = 1'b1;
            ack_d   = 1'b0;
            err_d   = 1'b0;
        end
        cpu_req_d = ready_d & turn_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            board      <= BOARD_EMPTY;
            turn       <= FIRST_PLAYER;
            gs_q       <= GS_PLAYING;
            move_count <= 4'd0;
            ready_q    <= 1'b1;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            cpu_req    <= FIRST_PLAYER;
            lat_player <= 1'b0;
            lat_coord  <= 4'd0;
        end else begin
            board      <= board_d;
            turn       <= turn_d;
            gs_q       <= gs_d;
            move_count <= count_d;
            ready_q    <= ready_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            cpu_req    <= cpu_req_d;
            lat_player <= lat_player_d;
            lat_coord  <= lat_coord_d;
        end
    end

endmodule

// File: tb/tb_board_referee.sv
// Scoreboard bench for board_referee: driver queues the expected pulse per move, monitor checks it.
module tb_board_referee;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        new_game = 1'b0;
    logic [17:0] board;
    logic        turn, cpu_req;
    logic [1:0]  game_state;
    logic [3:0]  move_count;

    board_referee_if mi();

    board_referee #(.FIRST_PLAYER(1'b0)) dut (
        .clock      (clock),
        .reset      (reset),
        .new_game   (new_game),
        .mv         (mi),
        .board      (board),
        .turn       (turn),
        .cpu_req    (cpu_req),
        .game_state (game_state),
        .move_count (move_count)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        bit          is_ack;
        int          due;
        logic [17:0] brd;
        logic        trn;
        logic [1:0]  gs;
        logic [3:0]  cnt;
        logic        rdy;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int n_cmp = 0;
    int n_bad = 0;

    logic [17:0] m_board;
    logic        m_turn;
    logic [1:0]  m_gs;
    logic [3:0]  m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        m_board = 18'h2AAAA;
        m_turn  = 1'b0;
        m_gs    = 2'd0;
        m_cnt   = 4'd0;
    endtask

    task automatic check_state(input string tag, input logic rdy);
        chk({tag, "_board"},      32'(board),         32'(m_board));
        chk({tag, "_turn"},       32'(turn),          32'(m_turn));
        chk({tag, "_game_state"}, 32'(game_state),    32'(m_gs));
        chk({tag, "_move_count"}, 32'(move_count),    32'(m_cnt));
        chk({tag, "_move_ready"}, 32'(mi.move_ready), 32'(rdy));
        chk({tag, "_cpu_req"},    32'(cpu_req),       32'(rdy & m_turn));
        chk({tag, "_no_pulse"},   32'({mi.move_ack, mi.move_err}), 32'd0);
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (mi.move_ready) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_move(input logic p, input logic [3:0] c, input bit legal, input logic [1:0] gs);
        bit   ok;
        exp_t e;
        wait_ready(ok);
        if (!ok) begin
            chk("ready_timeout", 32'd0, 32'd1);
            return;
        end
        mi.move_valid  = 1'b1;
        mi.move_player = p;
        mi.move_coord  = c;
        if (legal) begin
            for (int i = 0; i < 9; i++) begin
                if (4'(i) == c) m_board[2*i +: 2] = {1'b0, p};
            end
            m_cnt  = m_cnt + 4'd1;
            m_turn = ~m_turn;
            m_gs   = gs;
        end
        e.is_ack = legal;
        e.due    = cyc + (legal ? 3 : 2);
        e.brd    = m_board;
        e.trn    = m_turn;
        e.gs     = m_gs;
        e.cnt    = m_cnt;
        e.rdy    = (m_gs == 2'd0);
        sb.push_back(e);
        @(negedge clock);
        mi.move_valid = 1'b0;
    endtask

    // Handshake a move without queuing a response; used when the move must be discarded.
    task automatic raw_move(input logic p, input logic [3:0] c);
        bit ok;
        wait_ready(ok);
        if (!ok) chk("raw_ready_timeout", 32'd0, 32'd1);
        mi.move_valid  = 1'b1;
        mi.move_player = p;
        mi.move_coord  = c;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clock);
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic ng_pulse(input string tag);
        @(negedge clock);
        new_game = 1'b1;
        @(negedge clock);
        new_game = 1'b0;
        model_clear();
        check_state(tag, 1'b1);
    endtask

    always @(negedge clock) begin
        if (mi.move_ack || mi.move_err) begin
            chk("ack_err_exclusive", 32'(mi.move_ack & mi.move_err), 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_pulse", 32'({mi.move_ack, mi.move_err}), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("pulse_kind",  32'(mi.move_ack),   32'(mon_e.is_ack));
                chk("pulse_cycle", 32'(cyc),           32'(mon_e.due));
                chk("pulse_board", 32'(board),         32'(mon_e.brd));
                chk("pulse_turn",  32'(turn),          32'(mon_e.trn));
                chk("pulse_state", 32'(game_state),    32'(mon_e.gs));
                chk("pulse_count", 32'(move_count),    32'(mon_e.cnt));
                chk("pulse_ready", 32'(mi.move_ready), 32'(mon_e.rdy));
                chk("pulse_cpu",   32'(cpu_req),       32'(mon_e.rdy & mon_e.trn));
            end
        end
    end

    initial begin
        mi.move_valid  = 1'b0;
        mi.move_player = 1'b0;
        mi.move_coord  = 4'd0;
        model_clear();
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_state("reset", 1'b1);

        // X 0, O 4: two acks, turn back to X
        do_move(1'b0, 4'd0, 1'b1, 2'd0);
        do_move(1'b1, 4'd4, 1'b1, 2'd0);
        drain();
        check_state("two_moves", 1'b1);

        // occupied cell, coord 9, wrong player
        ng_pulse("ng1");
        do_move(1'b0, 4'd0, 1'b1, 2'd0);
        do_move(1'b1, 4'd0, 1'b0, 2'd0);
        do_move(1'b1, 4'd9, 1'b0, 2'd0);
        do_move(1'b0, 4'd5, 1'b0, 2'd0);
        drain();
        check_state("illegal", 1'b1);

        // X wins on the top row; later requests are ignored
        ng_pulse("ng2");
        do_move(1'b0, 4'd0, 1'b1, 2'd0);
        do_move(1'b1, 4'd3, 1'b1, 2'd0);
        do_move(1'b0, 4'd1, 1'b1, 2'd0);
        do_move(1'b1, 4'd4, 1'b1, 2'd0);
        do_move(1'b0, 4'd2, 1'b1, 2'd1);
        drain();
        check_state("x_win", 1'b0);
        @(negedge clock);
        mi.move_valid  = 1'b1;
        mi.move_player = 1'b1;
        mi.move_coord  = 4'd8;
        repeat (5) @(negedge clock);
        mi.move_valid = 1'b0;
        repeat (3) @(negedge clock);
        check_state("over_hold", 1'b0);

        // full board with no line
        ng_pulse("ng3");
        do_move(1'b0, 4'd0, 1'b1, 2'd0);
        do_move(1'b1, 4'd1, 1'b1, 2'd0);
        do_move(1'b0, 4'd2, 1'b1, 2'd0);
        do_move(1'b1, 4'd4, 1'b1, 2'd0);
        do_move(1'b0, 4'd3, 1'b1, 2'd0);
        do_move(1'b1, 4'd5, 1'b1, 2'd0);
        do_move(1'b0, 4'd7, 1'b1, 2'd0);
        do_move(1'b1, 4'd6, 1'b1, 2'd0);
        do_move(1'b0, 4'd8, 1'b1, 2'd3);
        drain();
        check_state("draw", 1'b0);

        // ninth move completes diagonal 0-4-8: win, not draw
        ng_pulse("ng4");
        do_move(1'b0, 4'd0, 1'b1, 2'd0);
        do_move(1'b1, 4'd1, 1'b1, 2'd0);
        do_move(1'b0, 4'd2, 1'b1, 2'd0);
        do_move(1'b1, 4'd3, 1'b1, 2'd0);
        do_move(1'b0, 4'd4, 1'b1, 2'd0);
        do_move(1'b1, 4'd5, 1'b1, 2'd0);
        do_move(1'b0, 4'd7, 1'b1, 2'd0);
        do_move(1'b1, 4'd6, 1'b1, 2'd0);
        do_move(1'b0, 4'd8, 1'b1, 2'd1);
        drain();
        check_state("win_on_nine", 1'b0);

        // O wins on diagonal 2-4-6
        ng_pulse("ng5");
        do_move(1'b0, 4'd0, 1'b1, 2'd0);
        do_move(1'b1, 4'd4, 1'b1, 2'd0);
        do_move(1'b0, 4'd8, 1'b1, 2'd0);
        do_move(1'b1, 4'd2, 1'b1, 2'd0);
        do_move(1'b0, 4'd1, 1'b1, 2'd0);
        do_move(1'b1, 4'd6, 1'b1, 2'd2);
        drain();
        check_state("o_win", 1'b0);

        // new_game in the same cycle as a move handshake
        ng_pulse("ng6");
        do_move(1'b0, 4'd0, 1'b1, 2'd0);
        drain();
        raw_move(1'b1, 4'd4);
        new_game = 1'b1;
        @(negedge clock);
        new_game      = 1'b0;
        mi.move_valid = 1'b0;
        model_clear();
        check_state("ng_with_move", 1'b1);
        repeat (4) @(negedge clock);
        check_state("ng_with_move_late", 1'b1);

        // new_game while the move sits in EVAL
        raw_move(1'b0, 4'd4);
        @(negedge clock);
        mi.move_valid = 1'b0;
        @(negedge clock);
        new_game = 1'b1;
        @(negedge clock);
        new_game = 1'b0;
        check_state("ng_in_eval", 1'b1);
        repeat (4) @(negedge clock);
        check_state("ng_in_eval_late", 1'b1);

        // reset while the move sits in CHECK
        do_move(1'b0, 4'd0, 1'b1, 2'd0);
        drain();
        raw_move(1'b1, 4'd4);
        @(negedge clock);
        mi.move_valid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        model_clear();
        check_state("reset_in_check", 1'b1);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        check_state("reset_in_check_late", 1'b1);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
